// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// State encodings, grant codes and the abort read-data default.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts owner strobes without ack and
// raises a one-cycle abort when the limit is reached.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic stb,
  input  logic ack,
  output logic abort
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // Abort fires in the stalled cycle that completes TIMEOUT.
  assign abort = busy & stb & ~ack & (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !busy || ack || abort) begin
      cnt_q <= '0;
    end else if (stb) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/wishbone_2mst_arbiter.sv
// Round-robin 2-master Wishbone arbiter, burst-granular ownership.
// Optional stall watchdog enabled by `define WB_ARB_TIMEOUT_EN.
module wishbone_2mst_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter int          TW       = 8,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        err_o
);

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   own0, own1;
  logic   abort;

  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_adr, o_dat;
  logic [3:0]  o_sel;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // last = 1 means m1 was granted most recently.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: if (!m0_cyc_i) state_d = IDLE;
      OWN1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  always_comb begin
    grant_o = GRANT_NONE;
    unique case (1'b1)
      own0:    grant_o = GRANT_M0;
      own1:    grant_o = GRANT_M1;
      default: grant_o = GRANT_NONE;
    endcase
  end

  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    unique case (1'b1)
      own0: begin
        o_cyc = m0_cyc_i;
        o_stb = m0_stb_i;
        o_we  = m0_we_i;
        o_adr = m0_adr_i;
        o_dat = m0_dat_i;
        o_sel = m0_sel_i;
      end
      own1: begin
        o_cyc = m1_cyc_i;
        o_stb = m1_stb_i;
        o_we  = m1_we_i;
        o_adr = m1_adr_i;
        o_dat = m1_dat_i;
        o_sel = m1_sel_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wdog (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .busy  (o_cyc),
    .stb   (o_stb),
    .ack   (s_ack_i),
    .abort (abort)
  );
`else
  wire unused_cfg = (TIMEOUT > 0) && (TW > 0);
  assign abort = 1'b0;
`endif

  // o_* are already zero in IDLE, which gates cyc/stb.
  assign s_cyc_o = o_cyc;
  assign s_stb_o = o_stb & ~abort;
  assign s_we_o  = o_we;
  assign s_adr_o = o_adr;
  assign s_dat_o = o_dat;
  assign s_sel_o = o_sel;

  assign m0_ack_o = own0 & (s_ack_i | abort);
  assign m1_ack_o = own1 & (s_ack_i | abort);
  assign m0_dat_o = own0 ? (abort ? ERR_DATA : s_dat_i) : '0;
  assign m1_dat_o = own1 ? (abort ? ERR_DATA : s_dat_i) : '0;

  assign err_o = abort;

endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// Self-checking bench for wishbone_2mst_arbiter.
// Directed scenarios plus random traffic against a grant model.
module tb_wishbone_2mst_arbiter;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat, m0_rd;
  logic [3:0]  m0_sel;
  logic m0_ack;
  logic m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat, m1_rd;
  logic [3:0]  m1_sel;
  logic m1_ack;
  logic s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic s_ack;
  logic [1:0] grant;
  logic err;

  always #5 clk = ~clk;

  wishbone_2mst_arbiter #(
    .TIMEOUT  (TO),
    .TW       (8),
    .ERR_DATA (ERRD)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_dat),
    .m0_sel_i (m0_sel),
    .m0_dat_o (m0_rd),
    .m0_ack_o (m0_ack),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_dat),
    .m1_sel_i (m1_sel),
    .m1_dat_o (m1_rd),
    .m1_ack_o (m1_ack),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_sel_o  (s_sel),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .grant_o  (grant),
    .err_o    (err)
  );

  logic [139:0] obs;
  assign obs = {s_cyc, s_stb, s_we, s_adr, s_wdat,
                s_sel, m0_ack, m0_rd, m1_ack, m1_rd,
                grant, err};

  int n_chk = 0;
  int n_fail = 0;

  // Model: owner 0 = none, 1 = m0, 2 = m1.
  int own = 0;
  bit lst = 1'b1;
  int stall = 0;

  task automatic zero_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_adr = 0; m1_dat = 0; m1_sel = 0;
    s_ack = 0; s_rdat = 0;
  endtask

  task automatic tick();
    bit oc, os;
    oc = (own == 1) ? m0_cyc : (own == 2) ? m1_cyc : 1'b0;
    os = (own == 1) ? m0_stb : (own == 2) ? m1_stb : 1'b0;
    if (rst) begin
      own = 0; lst = 1'b1; stall = 0;
    end else begin
      if (own == 0 || !oc || s_ack) stall = 0;
      else if (os) stall = (WD && stall == TO - 1) ? 0 : stall + 1;
      if (own == 0) begin
        if (m0_cyc && (!m1_cyc || lst)) begin
          own = 1; lst = 1'b0;
        end else if (m1_cyc) begin
          own = 2; lst = 1'b1;
        end
      end else if (!oc) begin
        own = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    zero_inputs();
    rst = 1;
    s_ack = 1;
    s_rdat = $urandom;
    tick(); tick();
    #2;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 0;
    tick();
    #2;
    n_chk++;
    if ({m0_ack, m1_ack, err, grant, s_cyc} !== 6'b0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got %b want 0",
               {m0_ack, m1_ack, err, grant, s_cyc});
    end
    s_ack = 0;
    tick();
  endtask

  task automatic test_single_write();
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    m0_adr = 32'h3003_0004;
    m0_dat = 32'h1234_5678;
    m0_sel = 4'hF;
    #2;
    n_chk++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_latency: got %b want 000", {grant, s_cyc});
    end
    tick(); #2;
    n_chk++;
    if ({grant, s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel, m0_ack}
        !== {2'b01, 3'b111, 32'h3003_0004, 32'h1234_5678,
             4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_request: got %b %h %h %h want 01 3003_0004 12345678 f",
               grant, s_adr, s_wdat, s_sel);
    end
    tick();
    s_ack = 1;
    #2;
    n_chk++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ack: got %b want 10", {m0_ack, m1_ack});
    end
    tick();
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #2;
    n_chk++;
    if ({grant, s_cyc} !== 3'b010) begin
      n_fail++;
      $display("FAIL wr_drop: got %b want 010", {grant, s_cyc});
    end
    tick(); #2;
    n_chk++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_idle: got %b want 00", grant);
    end
  endtask

  task automatic test_tie();
    rst = 1;
    tick();
    rst = 0;
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_first: got %b want 01", grant);
    end
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL tie_gap: got %b want 00", grant);
    end
    tick(); #2;
    n_chk++;
    if ({grant, s_cyc} !== 3'b101) begin
      n_fail++;
      $display("FAIL tie_second: got %b want 101", {grant, s_cyc});
    end
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_rr: got %b want 01", grant);
    end
    zero_inputs();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    m1_cyc = 1; m1_stb = 1;
    m1_adr = $urandom;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL burst_grant: got %b want 10", grant);
    end
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      s_rdat = v;
      s_ack = 1;
      #2;
      n_chk++;
      if ({grant, m1_ack, m1_rd, m0_ack, m0_rd}
          !== {2'b10, 1'b1, v, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL burst_read%0d: got %b %b %h %b want 10 1 %h 0",
                 i, grant, m1_ack, m1_rd, m0_ack, v);
      end
      tick();
      s_ack = 0;
      #2;
      n_chk++;
      if ({grant, m0_ack} !== 3'b100) begin
        n_fail++;
        $display("FAIL burst_gap%0d: got %b want 100", i, {grant, m0_ack});
      end
      tick();
    end
    m1_cyc = 0; m1_stb = 0;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_idle: got %b want 00", grant);
    end
    tick(); #2;
    n_chk++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_handover: got %b want 01", grant);
    end
    zero_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'h3;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_grant: got %b want 10", grant);
    end
    tick();
    rst = 1;
    tick(); #2;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h want 0", obs);
    end
    rst = 0;
    zero_inputs();
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick(); #2;
    n_chk++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_last: got %b want 01", grant);
    end
    zero_inputs();
    tick(); tick();
  endtask

  task automatic test_stall();
    m0_cyc = 1; m0_stb = 1;
    m0_adr = 32'h3001_0000;
    tick();
    if (WD) begin
      for (int i = 1; i <= TO; i++) begin
        #2;
        n_chk++;
        if (i < TO) begin
          if ({m0_ack, err, s_stb} !== 3'b001) begin
            n_fail++;
            $display("FAIL stall%0d: got %b want 001",
                     i, {m0_ack, err, s_stb});
          end
        end else begin
          if ({m0_ack, err, s_stb, m0_rd} !== {3'b110, ERRD}) begin
            n_fail++;
            $display("FAIL stall_abort: got %b %h want 110 %h",
                     {m0_ack, err, s_stb}, m0_rd, ERRD);
          end
        end
        tick();
      end
      #2;
      n_chk++;
      if ({grant, s_stb, err, m0_ack} !== 5'b01100) begin
        n_fail++;
        $display("FAIL stall_keep: got %b want 01100",
                 {grant, s_stb, err, m0_ack});
      end
    end else begin
      for (int i = 0; i < 1000; i++) begin
        #2;
        n_chk++;
        if ({grant, s_cyc, s_stb, m0_ack, err} !== 6'b011100) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got %b want 011100",
                   i, {grant, s_cyc, s_stb, m0_ack, err});
        end
        tick();
      end
    end
    zero_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic oc, os, ow, ab;
    logic [31:0] oa, od;
    logic [3:0]  osl;
    logic [1:0]  g;
    logic [139:0] exp;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(7) == 0) m1_cyc = ~m1_cyc;
      m0_stb = ($urandom_range(3) != 0);
      m1_stb = ($urandom_range(3) != 0);
      m0_we = $urandom; m1_we = $urandom;
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = $urandom; m1_dat = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      s_ack = ($urandom_range(4) == 0);
      s_rdat = $urandom;
      rst = ($urandom_range(299) == 0);
      #2;
      oc = 0; os = 0; ow = 0; oa = 0; od = 0; osl = 0; g = 2'b00;
      if (own == 1) begin
        oc = m0_cyc; os = m0_stb; ow = m0_we;
        oa = m0_adr; od = m0_dat; osl = m0_sel; g = 2'b01;
      end else if (own == 2) begin
        oc = m1_cyc; os = m1_stb; ow = m1_we;
        oa = m1_adr; od = m1_dat; osl = m1_sel; g = 2'b10;
      end
      ab = WD && oc && os && !s_ack && (stall == TO - 1);
      exp = {oc, os & ~ab, ow, oa, od, osl,
             (own == 1) & (s_ack | ab),
             (own == 1) ? (ab ? ERRD : s_rdat) : 32'h0,
             (own == 2) & (s_ack | ab),
             (own == 2) ? (ab ? ERRD : s_rdat) : 32'h0,
             g, ab};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random%0d: got %h want %h", n, obs, exp);
      end
      tick();
    end
    rst = 0;
    zero_inputs();
    tick(); tick();
  endtask

  initial begin
    rst = 1;
    zero_inputs();
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
